// File: rtl/inst_fetch.sv
// rtl/inst_fetch.sv - instruction fetch stage with a 2-entry {pc,data} queue toward decode
// Optional issue/stall counters are built when FETCH_PERF_EN is defined.
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        sys_clk,
  input  logic        sys_arstn,
  input  logic        run_en,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc,
  output logic        fetch_fault
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_issued,
  output logic [31:0] perf_stall
`endif
);
  typedef enum logic {RUN = 1'b0, FAULT = 1'b1} state_t;

  state_t            state_q, state_d;
  logic [31:0]       pc_q, pc_d;
  logic [31:0]       req_pc_q, req_pc_d;
  logic              inflight_q, inflight_d;
  logic [1:0][31:0]  qpc_q, qpc_d;
  logic [1:0][31:0]  qdata_q, qdata_d;
  logic              head_q, head_d;
  logic [1:0]        count_q, count_d;

  logic pop, push, issue, redir_ok, tail;

  assign inst_valid  = (count_q != 2'd0);
  assign imem_addr   = pc_q;
  assign inst_pc     = qpc_q[head_q];
  assign inst_data   = qdata_q[head_q];
  assign fetch_fault = (state_q == FAULT);

  always_comb begin
    pop      = inst_valid & inst_ready;
    redir_ok = redirect_valid & (redirect_pc[1:0] == 2'b00);
    // Credit covers queued entries plus the read still in flight.
    issue    = (state_q == RUN) & run_en & ~redirect_valid &
               (({1'b0, count_q} + {2'b0, inflight_q}) < (3'd2 + {2'b0, pop}));
    push     = inflight_q & ~redirect_valid;
    tail     = head_q ^ count_q[0];

    state_d    = state_q;
    pc_d       = pc_q;
    req_pc_d   = req_pc_q;
    inflight_d = inflight_q;
    qpc_d      = qpc_q;
    qdata_d    = qdata_q;
    head_d     = head_q;
    count_d    = count_q;

    if (redirect_valid) begin
      count_d    = 2'd0;
      inflight_d = 1'b0;
      if (redir_ok) begin
        pc_d = redirect_pc;
      end else begin
        state_d = FAULT;
      end
    end else begin
      inflight_d = issue;
      if (issue) begin
        req_pc_d = pc_q;
        pc_d     = pc_q + 32'd4;
      end
      if (push) begin
        qpc_d[tail]   = req_pc_q;
        qdata_d[tail] = imem_data;
      end
      if (pop) begin
        head_d = ~head_q;
      end
      count_d = count_q + {1'b0, push} - {1'b0, pop};
    end
  end

  always_ff @(posedge sys_clk or negedge sys_arstn) begin
    if (!sys_arstn) begin
      state_q    <= RUN;
      pc_q       <= RESET_PC;
      req_pc_q   <= 32'd0;
      inflight_q <= 1'b0;
      qpc_q      <= '0;
      qdata_q    <= '0;
      head_q     <= 1'b0;
      count_q    <= 2'd0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_pc_q   <= req_pc_d;
      inflight_q <= inflight_d;
      qpc_q      <= qpc_d;
      qdata_q    <= qdata_d;
      head_q     <= head_d;
      count_q    <= count_d;
    end
  end

`ifdef FETCH_PERF_EN
  logic [31:0] perf_issued_q, perf_issued_d;
  logic [31:0] perf_stall_q, perf_stall_d;

  always_comb begin
    perf_issued_d = perf_issued_q + {31'd0, issue};
    perf_stall_d  = perf_stall_q + {31'd0, (state_q == RUN) & run_en & ~issue};
    if (redir_ok) begin
      perf_issued_d = 32'd0;
      perf_stall_d  = 32'd0;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_arstn) begin
    if (!sys_arstn) begin
      perf_issued_q <= 32'd0;
      perf_stall_q  <= 32'd0;
    end else begin
      perf_issued_q <= perf_issued_d;
      perf_stall_q  <= perf_stall_d;
    end
  end

  assign perf_issued = perf_issued_q;
  assign perf_stall  = perf_stall_q;
`endif
endmodule

// File: tb/tb_inst_fetch.sv
// tb/tb_inst_fetch.sv - randomized self-checking bench for inst_fetch
// Directed phases pin the reference queue model, then random traffic runs against it.
module tb_inst_fetch;
  logic        sys_clk = 1'b0;
  logic        sys_arstn = 1'b0;
  logic        run_en = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'd0;
  logic        inst_ready = 1'b0;
  logic [31:0] imem_addr, imem_data, inst_data, inst_pc;
  logic        inst_valid, fetch_fault;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_issued, perf_stall;
`endif

  int n_vec = 0;
  int n_fail = 0;

  logic [31:0] mem [16];

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] data;
  } ent_t;

  ent_t        m_q[$];
  logic [31:0] m_pc, m_req_pc, m_issued, m_stall;
  bit          m_inflight, m_fault;
  bit          chk_en = 1'b0;

  always #5 sys_clk = ~sys_clk;

  inst_fetch dut (
    .sys_clk        (sys_clk),
    .sys_arstn      (sys_arstn),
    .run_en         (run_en),
    .imem_addr      (imem_addr),
    .imem_data      (imem_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_data      (inst_data),
    .inst_pc        (inst_pc),
    .fetch_fault    (fetch_fault)
`ifdef FETCH_PERF_EN
    ,
    .perf_issued    (perf_issued),
    .perf_stall     (perf_stall)
`endif
  );

  // Registered-read instruction memory.
  always @(posedge sys_clk) imem_data <= mem[imem_addr[5:2]];

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return mem[a[5:2]];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_pc       = 32'd0;
    m_req_pc   = 32'd0;
    m_inflight = 1'b0;
    m_fault    = 1'b0;
    m_issued   = 32'd0;
    m_stall    = 32'd0;
  endtask

  // Reference model: a queue of delivered {pc, word} plus one pending read.
  always @(posedge sys_clk) begin
    int   cnt;
    bit   pop, issue;
    ent_t e;
    if (sys_arstn) begin
      cnt   = m_q.size();
      pop   = (cnt != 0) && inst_ready;
      issue = !m_fault && run_en && !redirect_valid &&
              (cnt + int'(m_inflight) - int'(pop) < 2);
      if (redirect_valid && redirect_pc[1:0] == 2'b00) begin
        m_issued = 32'd0;
        m_stall  = 32'd0;
      end else begin
        if (issue) m_issued = m_issued + 32'd1;
        if (!m_fault && run_en && !issue) m_stall = m_stall + 32'd1;
      end
      if (redirect_valid) begin
        m_q.delete();
        m_inflight = 1'b0;
        if (redirect_pc[1:0] == 2'b00) m_pc = redirect_pc;
        else m_fault = 1'b1;
      end else begin
        if (pop) void'(m_q.pop_front());
        if (m_inflight) begin
          e.pc   = m_req_pc;
          e.data = word_at(m_req_pc);
          m_q.push_back(e);
        end
        m_inflight = issue;
        if (issue) begin
          m_req_pc = m_pc;
          m_pc     = m_pc + 32'd4;
        end
      end
    end
  end

  always @(negedge sys_clk) begin
    if (chk_en && sys_arstn) begin
      chk("inst_valid", {31'd0, inst_valid}, {31'd0, m_q.size() != 0});
      if (m_q.size() != 0) begin
        chk("inst_pc", inst_pc, m_q[0].pc);
        chk("inst_data", inst_data, m_q[0].data);
      end
      chk("imem_addr", imem_addr, m_pc);
      chk("fetch_fault", {31'd0, fetch_fault}, {31'd0, m_fault});
`ifdef FETCH_PERF_EN
      chk("perf_issued", perf_issued, m_issued);
      chk("perf_stall", perf_stall, m_stall);
`endif
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic hard_reset();
    #2 sys_arstn = 1'b0;
    #1;
    model_reset();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] r;
    for (int i = 0; i < 16; i++) mem[i] = 32'h100 + i;
    model_reset();
    run_en     = 1'b1;
    inst_ready = 1'b1;
    #1;
    chk("rst_imem_addr", imem_addr, 32'h0);
    chk("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
    chk("rst_inst_data", inst_data, 32'h0);
    chk("rst_inst_pc", inst_pc, 32'h0);
    chk("rst_fetch_fault", {31'd0, fetch_fault}, 32'd0);
    chk_en = 1'b1;
    @(negedge sys_clk);
    sys_arstn = 1'b1;

    // Straight line: first instruction two cycles after the first issue.
    cyc(1);
    chk("c1_valid", {31'd0, inst_valid}, 32'd0);
    chk("c1_addr", imem_addr, 32'h4);
    cyc(1);
    chk("c2_valid", {31'd0, inst_valid}, 32'd1);
    chk("c2_pc", inst_pc, 32'h0);
    chk("c2_data", inst_data, 32'h100);
    cyc(1);
    chk("c3_pc", inst_pc, 32'h4);
    chk("c3_data", inst_data, 32'h101);
    cyc(1);
    chk("c4_pc", inst_pc, 32'h8);

    // Backpressure for cycles 4..8.
    inst_ready = 1'b0;
    cyc(4);
    chk("bp_pc", inst_pc, 32'h8);
    chk("bp_addr", imem_addr, 32'h10);
    cyc(1);
    inst_ready = 1'b1;
    cyc(1);
    chk("rel_pc", inst_pc, 32'hC);
    chk("rel_addr", imem_addr, 32'h14);
    cyc(1);
    chk("rel2_pc", inst_pc, 32'h10);
    chk("rel2_data", inst_data, 32'h104);

    // Redirect with data queued and a read in flight.
    redirect_valid = 1'b1;
    redirect_pc    = 32'h20;
    cyc(1);
    redirect_valid = 1'b0;
    chk("rd1_valid", {31'd0, inst_valid}, 32'd0);
    chk("rd1_addr", imem_addr, 32'h20);
    cyc(1);
    chk("rd2_valid", {31'd0, inst_valid}, 32'd0);
    cyc(1);
    chk("rd3_valid", {31'd0, inst_valid}, 32'd1);
    chk("rd3_pc", inst_pc, 32'h20);
    chk("rd3_data", inst_data, 32'h108);
    cyc(1);

    // Wrap-around at the top of the address space.
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    cyc(1);
    redirect_valid = 1'b0;
    chk("wr1_addr", imem_addr, 32'hFFFF_FFFC);
    cyc(1);
    chk("wr2_addr", imem_addr, 32'h0);
    cyc(1);
    chk("wr3_pc", inst_pc, 32'hFFFF_FFFC);
    chk("wr3_data", inst_data, 32'h10F);
    cyc(1);
    chk("wr4_pc", inst_pc, 32'h0);

    // run_en drop with one read in flight: it still drains.
    run_en = 1'b0;
    cyc(1);
    chk("re1_valid", {31'd0, inst_valid}, 32'd1);
    chk("re1_pc", inst_pc, 32'h4);
    chk("re1_addr", imem_addr, 32'h8);
    cyc(1);
    chk("re2_valid", {31'd0, inst_valid}, 32'd0);
    cyc(1);
    chk("re3_addr", imem_addr, 32'h8);

    // Misaligned redirect.
    run_en         = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h22;
    cyc(1);
    redirect_valid = 1'b0;
    chk("mis_fault", {31'd0, fetch_fault}, 32'd1);
    chk("mis_valid", {31'd0, inst_valid}, 32'd0);
    chk("mis_addr", imem_addr, 32'h8);
    cyc(3);
    chk("mis_hold_addr", imem_addr, 32'h8);

    // Reset clears the fault, then reset again mid-stream.
    hard_reset();
    chk("rst2_fault", {31'd0, fetch_fault}, 32'd0);
    chk("rst2_addr", imem_addr, 32'h0);
    @(negedge sys_clk);
    sys_arstn = 1'b1;
    cyc(5);
    chk("pre_rst_valid", {31'd0, inst_valid}, 32'd1);
    hard_reset();
    chk("rst3_valid", {31'd0, inst_valid}, 32'd0);
    chk("rst3_addr", imem_addr, 32'h0);
    chk("rst3_pc", inst_pc, 32'h0);
    @(negedge sys_clk);
    sys_arstn = 1'b1;

    // Random traffic.
    repeat (4000) begin
      @(negedge sys_clk);
      redirect_valid = 1'b0;
      if ($urandom_range(0, 199) == 0) begin
        hard_reset();
        @(negedge sys_clk);
        sys_arstn = 1'b1;
      end
      inst_ready = ($urandom_range(0, 3) != 0);
      run_en     = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 15) == 0) begin
        r = $urandom();
        if ($urandom_range(0, 7) == 0) r[1:0] = 2'($urandom_range(1, 3));
        else r[1:0] = 2'b00;
        redirect_valid = 1'b1;
        redirect_pc    = r;
      end
    end
    @(negedge sys_clk);
    redirect_valid = 1'b0;
    cyc(2);
    chk_en = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
